// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - width derivations and sequencer state encoding for gate_sequencer
package gate_pkg;

  function automatic int gate_bitwidth(input int qn, input int qm);
    return qn + qm + 1;
  endfunction

  function automatic int gate_addr_bitwidth(input int ncol);
    return (ncol > 1) ? $clog2(ncol) : 1;
  endfunction

  typedef enum logic [2:0] {
    ST_FILL,
    ST_ARMED,
    ST_CLEAR,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } gate_state_t;

endpackage

// File: rtl/elem_buffer.sv
// rtl/elem_buffer.sv - input vector element store, one write port, one asynchronous read port
module elem_buffer
  import gate_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 18,
  parameter int AW    = gate_addr_bitwidth(DEPTH)
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  // No reset: contents are only read after a full FILL rewrites every entry.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/gate_sequencer.sv
// rtl/gate_sequencer.sv - buffers one input vector and sequences weightRAM columns into dot_prod
module gate_sequencer
  import gate_pkg::*;
#(
  parameter int NROW     = 16,
  parameter int NCOL     = 8,
  parameter int QN       = 6,
  parameter int QM       = 11,
  parameter int PIPE_LAT = 2,
  localparam int BITWIDTH      = gate_bitwidth(QN, QM),
  localparam int ADDR_BITWIDTH = gate_addr_bitwidth(NCOL)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [BITWIDTH-1:0]      in_data,
  output logic                     in_ready,
  input  logic                     start,
  input  logic                     abort,
  output logic [ADDR_BITWIDTH-1:0] colAddress,
  output logic [BITWIDTH-1:0]      elemOut,
  output logic                     accEn,
  output logic                     accClr,
  output logic                     busy,
  output logic                     done
);

  if (NROW < 1 || NCOL < 2 || (NCOL & (NCOL - 1)) != 0 || PIPE_LAT < 0) begin : g_bad_param
    $error("gate_sequencer: NROW must be >= 1, NCOL a power of two >= 2, PIPE_LAT >= 0");
  end

  localparam int DCW = $clog2(PIPE_LAT + 2);
  localparam logic [DCW-1:0]           DRAIN_LAST = DCW'(PIPE_LAT);
  localparam logic [ADDR_BITWIDTH-1:0] COL_LAST   = ADDR_BITWIDTH'(NCOL - 1);

  gate_state_t                state_q, state_d;
  logic [ADDR_BITWIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITWIDTH-1:0]   col_q, col_d;
  logic [ADDR_BITWIDTH-1:0]   col_addr_q, col_addr_d;
  logic [DCW-1:0]             drain_cnt_q, drain_cnt_d;
  logic [BITWIDTH-1:0]        elem_q, elem_d;
  logic                       acc_en_q, acc_en_d;
  logic                       acc_clr_q, acc_clr_d;
  logic                       done_q, done_d;
  logic [BITWIDTH-1:0]        buf_rd_data;
  logic                       wr_en;

  assign in_ready = (state_q == ST_FILL);
  assign busy     = (state_q == ST_CLEAR) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign wr_en    = in_valid && in_ready && !abort;

  elem_buffer #(
    .DEPTH (NCOL),
    .WIDTH (BITWIDTH),
    .AW    (ADDR_BITWIDTH)
  ) u_elem_buffer (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (in_data),
    .rd_addr (col_q),
    .rd_data (buf_rd_data)
  );

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    col_d       = col_q;
    col_addr_d  = col_addr_q;
    drain_cnt_d = drain_cnt_q;
    elem_d      = '0;
    acc_en_d    = 1'b0;
    acc_clr_d   = 1'b0;
    done_d      = 1'b0;
    unique case (state_q)
      ST_FILL: begin
        if (wr_en) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == COL_LAST) state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (start) begin
          state_d   = ST_CLEAR;
          acc_clr_d = 1'b1;
        end
      end
      ST_CLEAR: begin
        state_d    = ST_RUN;
        col_d      = '0;
        col_addr_d = '0;
      end
      ST_RUN: begin
        // Element for col_q lands one cycle after its address, matching the RAM read.
        col_d      = col_q + 1'b1;
        col_addr_d = col_q + 1'b1;
        elem_d     = buf_rd_data;
        acc_en_d   = 1'b1;
        if (col_q == COL_LAST) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d  = ST_FILL;
        wr_ptr_d = '0;
      end
      default: state_d = ST_FILL;
    endcase
    if (abort) begin
      state_d     = ST_FILL;
      wr_ptr_d    = '0;
      col_d       = '0;
      col_addr_d  = '0;
      drain_cnt_d = '0;
      elem_d      = '0;
      acc_en_d    = 1'b0;
      acc_clr_d   = 1'b0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_FILL;
      wr_ptr_q    <= '0;
      col_q       <= '0;
      col_addr_q  <= '0;
      drain_cnt_q <= '0;
      elem_q      <= '0;
      acc_en_q    <= 1'b0;
      acc_clr_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      col_q       <= col_d;
      col_addr_q  <= col_addr_d;
      drain_cnt_q <= drain_cnt_d;
      elem_q      <= elem_d;
      acc_en_q    <= acc_en_d;
      acc_clr_q   <= acc_clr_d;
      done_q      <= done_d;
    end
  end

  assign colAddress = col_addr_q;
  assign elemOut    = elem_q;
  assign accEn      = acc_en_q;
  assign accClr     = acc_clr_q;
  assign done       = done_q;

endmodule

// File: tb/tb_gate_sequencer.sv
// tb/tb_gate_sequencer.sv - directed vector table plus corner-case sequences for gate_sequencer
module tb_gate_sequencer;

  localparam int BW = 18;
  localparam int AW = 3;
  localparam int OW = 1 + 1 + AW + BW + 1 + 1 + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [BW-1:0] in_data = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          in_ready;
  logic [AW-1:0] colAddress;
  logic [BW-1:0] elemOut;
  logic          accEn, accClr, busy, done;

  gate_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .start      (start),
    .abort      (abort),
    .colAddress (colAddress),
    .elemOut    (elemOut),
    .accEn      (accEn),
    .accClr     (accClr),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          iv;
    logic [BW-1:0] d;
    logic          st;
    logic          ab;
    logic [OW-1:0] exp;
  } vec_t;

  vec_t          vecs [23];
  logic [BW-1:0] fv [8];
  int            checks = 0;
  int            errors = 0;

  function automatic logic [OW-1:0] o(input logic ir, input logic bz, input logic [AW-1:0] ca,
                                      input logic [BW-1:0] eo, input logic ae, input logic ac,
                                      input logic dn);
    return {ir, bz, ca, eo, ae, ac, dn};
  endfunction

  function automatic logic [OW-1:0] outs();
    return {in_ready, busy, colAddress, elemOut, accEn, accClr, done};
  endfunction

  function automatic logic [BW-1:0] q(input int k);
    return BW'(k * 2048);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic sv(input int i, input logic iv, input logic [BW-1:0] d, input logic st,
                    input logic [OW-1:0] e);
    vecs[i].iv  = iv;
    vecs[i].d   = d;
    vecs[i].st  = st;
    vecs[i].ab  = 1'b0;
    vecs[i].exp = e;
  endtask

  task automatic load_frame();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = fv[i];
      step();
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic run_frame(input string tag);
    int            n_en = 0;
    int            n_clr = 0;
    int            n_done = 0;
    int            done_at = -1;
    logic [AW-1:0] prev_col;
    start = 1'b1;
    step();
    start = 1'b0;
    if (accClr) n_clr++;
    prev_col = colAddress;
    for (int e = 1; e <= 24; e++) begin
      step();
      if (accEn) begin
        if (n_en < 8) begin
          chk({tag, "_elem"}, 64'(elemOut), 64'(fv[n_en]));
          chk({tag, "_col_lag"}, 64'(prev_col), 64'(n_en));
        end
        n_en++;
      end else begin
        chk({tag, "_elem_zero"}, 64'(elemOut), 64'(0));
      end
      if (accClr) n_clr++;
      if (done) begin
        n_done++;
        if (done_at < 0) done_at = e;
      end
      prev_col = colAddress;
    end
    chk({tag, "_accen_cycles"}, 64'(n_en), 64'(8));
    chk({tag, "_accclr_pulses"}, 64'(n_clr), 64'(1));
    chk({tag, "_done_pulses"}, 64'(n_done), 64'(1));
    chk({tag, "_done_latency"}, 64'(done_at), 64'(12));
    chk({tag, "_ready_after"}, 64'(in_ready), 64'(1));
  endtask

  task automatic watch_idle(input string tag, input int n);
    int n_done = 0;
    int n_clr = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (done) n_done++;
      if (accClr) n_clr++;
    end
    chk({tag, "_no_done"}, 64'(n_done), 64'(0));
    chk({tag, "_no_clr"}, 64'(n_clr), 64'(0));
    chk({tag, "_ready"}, 64'(in_ready), 64'(1));
  endtask

  task automatic wait_col(input string tag, input logic [AW-1:0] c);
    for (int w = 0; w < 20 && !(busy && colAddress == c && !accClr); w++) step();
    chk({tag, "_reach_col"}, 64'(colAddress), 64'(c));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("reset_async", 64'(outs()), 64'(o(1, 0, 0, 0, 0, 0, 0)));
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("reset_release", 64'(outs()), 64'(o(1, 0, 0, 0, 0, 0, 0)));

    // Main frame 1.0..8.0, with start during FILL and RUN and in_valid during RUN.
    sv(0,  1, q(1), 0, o(1, 0, 0, 0, 0, 0, 0));
    sv(1,  1, q(2), 0, o(1, 0, 0, 0, 0, 0, 0));
    sv(2,  1, q(3), 0, o(1, 0, 0, 0, 0, 0, 0));
    sv(3,  1, q(4), 1, o(1, 0, 0, 0, 0, 0, 0));
    sv(4,  1, q(5), 0, o(1, 0, 0, 0, 0, 0, 0));
    sv(5,  1, q(6), 0, o(1, 0, 0, 0, 0, 0, 0));
    sv(6,  1, q(7), 0, o(1, 0, 0, 0, 0, 0, 0));
    sv(7,  1, q(8), 0, o(0, 0, 0, 0, 0, 0, 0));
    sv(8,  0, '0,   0, o(0, 0, 0, 0, 0, 0, 0));
    sv(9,  0, '0,   1, o(0, 1, 0, 0, 0, 1, 0));
    sv(10, 0, '0,   0, o(0, 1, 0, 0, 0, 0, 0));
    sv(11, 0, '0,   0, o(0, 1, 1, q(1), 1, 0, 0));
    sv(12, 0, '0,   0, o(0, 1, 2, q(2), 1, 0, 0));
    sv(13, 0, '0,   1, o(0, 1, 3, q(3), 1, 0, 0));
    sv(14, 1, 18'h3ffff, 0, o(0, 1, 4, q(4), 1, 0, 0));
    sv(15, 0, '0,   0, o(0, 1, 5, q(5), 1, 0, 0));
    sv(16, 0, '0,   0, o(0, 1, 6, q(6), 1, 0, 0));
    sv(17, 0, '0,   0, o(0, 1, 7, q(7), 1, 0, 0));
    sv(18, 0, '0,   0, o(0, 1, 0, q(8), 1, 0, 0));
    sv(19, 0, '0,   0, o(0, 1, 0, 0, 0, 0, 0));
    sv(20, 0, '0,   0, o(0, 1, 0, 0, 0, 0, 0));
    sv(21, 0, '0,   0, o(0, 0, 0, 0, 0, 0, 1));
    sv(22, 0, '0,   0, o(1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 23; i++) begin
      in_valid = vecs[i].iv;
      in_data  = vecs[i].d;
      start    = vecs[i].st;
      abort    = vecs[i].ab;
      step();
      chk($sformatf("vec%0d", i), 64'(outs()), 64'(vecs[i].exp));
    end
    in_valid = 1'b0;
    in_data  = '0;
    start    = 1'b0;

    // Toggled in_valid: ARMED only on the eighth accept.
    for (int i = 0; i < 8; i++) fv[i] = q(10 + i);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = fv[i];
      step();
      chk($sformatf("toggle_ready%0d", i), 64'(in_ready), 64'(i < 7));
      in_valid = 1'b0;
      in_data  = 18'h15555;
      step();
    end
    in_data = '0;
    run_frame("toggle");

    // Abort at RUN col=4, then a clean frame of negative values.
    for (int i = 0; i < 8; i++) fv[i] = q(-(i + 1));
    load_frame();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_col("abort", 3'd4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_outs", 64'(outs()), 64'(o(1, 0, 0, 0, 0, 0, 0)));
    watch_idle("abort", 20);
    for (int i = 0; i < 8; i++) fv[i] = q(3 * i - 7);
    load_frame();
    run_frame("post_abort");

    // start and abort together while ARMED.
    load_frame();
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_outs", 64'(outs()), 64'(o(1, 0, 0, 0, 0, 0, 0)));
    watch_idle("start_abort", 16);

    // Reset asserted mid-RUN at col=3.
    load_frame();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_col("rst", 3'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_run", 64'(outs()), 64'(o(1, 0, 0, 0, 0, 0, 0)));
    step();
    reset = 1'b0;
    watch_idle("rst", 20);
    for (int i = 0; i < 8; i++) fv[i] = q(2 * i + 1);
    load_frame();
    run_frame("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
